mul_share_arbiter: RTL and testbench

Shares one 4x4 unsigned multiplier core (the `mul4bit` Wallace-tree datapath) among NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Operands are captured, sequenced through the combinational core, and the product is registered.
- The result is returned on a single response channel tagged with the requester index.
- Sits between client blocks and the multiplier, so the multiplier is never duplicated.

---
 rtl/mul_share_arbiter.sv | 120 ++++++++++++
 tb/tb_mul_share_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one 4x4 Wallace-tree multiplier among NREQ requesters.
// Ports: clk/rst_n (sync active-low reset); req_valid/req_ready/req_a/req_b per-requester request
// channel (operands packed 4 bits per requester); rsp_valid/rsp_ready/rsp_prod/rsp_id tagged
// response channel; busy high whenever not idle.
// Optional MUL_SHARE_ARBITER_STATS_EN adds saturating op_count and stall_cycles outputs.

// mul4bit: 4x4 unsigned multiplier, partial products reduced by two carry-save stages then one adder.
module mul4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] prod_o,
  output logic       cout_o
);
  logic [8:0] r [4];
  logic [8:0] s1, c1, s2, c2;
  always_comb begin
    for (int i = 0; i < 4; i++) r[i] = {5'b0, a_i & {4{b_i[i]}}} << i;
    s1 = r[0] ^ r[1] ^ r[2];
    c1 = ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2])) << 1;
    s2 = s1 ^ c1 ^ r[3];
    c2 = ((s1 & c1) | (s1 & r[3]) | (c1 & r[3])) << 1;
    {cout_o, prod_o} = s2 + c2;
  end
endmodule

module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_prod,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
`ifdef MUL_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]       op_count,
  output logic [15:0]       stall_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;
  state_e            state_q;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d, op_id_q, gnt, off;
  logic [IDW:0]      sum;
  logic [NREQ-1:0]   rot;
  logic              gnt_vld, mul_cout;
  logic [3:0]        op_a_q, op_b_q, sel_a, sel_b;
  logic [7:0]        prod;
  // Rotate so bit 0 is the rr_ptr requester; the lowest set bit is the winner's offset.
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> rr_ptr_q);
    gnt_vld = |req_valid;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) off = IDW'(k);
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    gnt = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) if (gnt == IDW'(k)) begin
      sel_a = req_a[4*k +: 4];
      sel_b = req_b[4*k +: 4];
    end
    req_ready = (rst_n && state_q == IDLE && gnt_vld) ? NREQ'(1) << gnt : '0;
    rr_ptr_d = (op_id_q == IDW'(NREQ - 1)) ? '0 : op_id_q + IDW'(1);
  end
  mul4bit u_mul (.a_i(op_a_q), .b_i(op_b_q), .prod_o(prod), .cout_o(mul_cout));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      op_id_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
          op_a_q  <= sel_a;
          op_b_q  <= sel_b;
          op_id_q <= gnt;
          state_q <= CALC;
        end
        CALC: begin
          rsp_prod  <= prod;
          rsp_id    <= op_id_q;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rr_ptr_q  <= rr_ptr_d;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = (state_q != IDLE);
`ifdef MUL_SHARE_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count     <= '0;
      stall_cycles <= '0;
    end else if (state_q == RESP) begin
      if (rsp_ready && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      if (!rsp_ready && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif
  // 15*15 fits in 8 bits, so the core's carry-out can never be set.
  a_no_cout: assert property (@(posedge clk) disable iff (!rst_n) !mul_cout);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench with a round-robin reference model for mul_share_arbiter.
module tb_mul_share_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [4*N-1:0] req_a = '0, req_b = '0;
  logic rsp_valid, busy;
  logic [7:0] rsp_prod;
  logic [1:0] rsp_id;
`ifdef MUL_SHARE_ARBITER_STATS_EN
  logic [15:0] op_count, stall_cycles;
`endif
  always #5 clk = ~clk;
  mul_share_arbiter #(.NREQ(N), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_prod(rsp_prod), .rsp_id(rsp_id), .busy(busy)
`ifdef MUL_SHARE_ARBITER_STATS_EN
    , .op_count(op_count), .stall_cycles(stall_cycles)
`endif
  );
  typedef struct { int id; int prod; int t; bit seen; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, rr_m = 0, opc_m = 0, stall_m = 0;
  bit outstanding = 0, started = 0;
  logic [N-1:0] last_rdy = '0;
  function automatic int pick(logic [N-1:0] v, int r);
    for (int k = 0; k < N; k++) if (v[(r + k) % N]) return (r + k) % N;
    return -1;
  endfunction
  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reset flushes the reference model: in-flight work is discarded, pointer returns to 0.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      outstanding <= 0;
      rr_m <= 0;
      opc_m <= 0;
      stall_m <= 0;
      started <= 1;
    end
  end
  // Grant side: the block is free exactly when no accepted operation is still unanswered.
  always @(negedge clk) begin
    int p, e;
    last_rdy = req_ready;
    if (started) begin
      p = pick(req_valid, rr_m);
      e = (!rst_n || outstanding || p < 0) ? 0 : (1 << p);
      check("req_ready", int'(req_ready), e);
      check("busy", int'(busy), int'(outstanding));
      if (e != 0) begin
        q.push_back('{p, int'(req_a[4*p +: 4]) * int'(req_b[4*p +: 4]), cyc, 1'b0});
        outstanding <= 1;
      end
    end
  end
  // Response side: pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (started) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_stale: rsp_valid=1 prod=%0d id=%0d with nothing outstanding", rsp_prod, rsp_id);
        end else begin
          if (!q[0].seen) begin
            check("latency", cyc - q[0].t, 2);
            q[0].seen = 1;
          end
          check("rsp_prod", int'(rsp_prod), q[0].prod);
          check("rsp_id", int'(rsp_id), q[0].id);
          if (rst_n && rsp_ready) begin
            rr_m <= (q[0].id + 1) % N;
            outstanding <= 0;
            opc_m <= opc_m + 1;
            void'(q.pop_front());
          end else if (rst_n) stall_m <= stall_m + 1;
        end
      end else if (q.size() != 0 && !q[0].seen && cyc > q[0].t + 2) begin
        checks++;
        errors++;
        $display("FAIL rsp_timeout: no rsp_valid for requester %0d granted at cycle %0d", q[0].id, q[0].t);
        q[0].seen = 1;
      end
`ifdef MUL_SHARE_ARBITER_STATS_EN
      check("op_count", int'(op_count), opc_m);
      check("stall_cycles", int'(stall_cycles), stall_m);
`endif
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(int i, int a, int b);
    req_valid[i] = 1'b1;
    req_a[4*i +: 4] = 4'(a);
    req_b[4*i +: 4] = 4'(b);
  endtask
  task automatic wait_grant(int i);
    for (int n = 0; n < 60; n++) begin
      tick();
      if (last_rdy[i]) begin
        req_valid[i] = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout: requester %0d never granted", i);
    req_valid[i] = 1'b0;
  endtask
  task automatic wait_any(output logic [N-1:0] g);
    g = '0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (last_rdy != '0) begin
        g = last_rdy;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout: no grant issued");
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      tick();
      if (!busy && !rsp_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: block never returned to idle");
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    logic [N-1:0] g;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_valid", int'(rsp_valid), 0);
    check("rst_prod", int'(rsp_prod), 0);
    check("rst_id", int'(rsp_id), 0);
    rsp_ready = 1'b1;
    set_req(1, 3, 5);
    wait_grant(1);
    wait_idle();
    set_req(2, 6, 7);
    wait_grant(2);
    pulse_reset();
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(rsp_valid), 0);
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(15), $urandom_range(15));
    wait_any(g);
    check("first_grant_after_reset", int'(g), 1);
    repeat (40) begin
      tick();
      for (int i = 0; i < N; i++) if (last_rdy[i]) set_req(i, $urandom_range(15), $urandom_range(15));
    end
    req_valid = '0;
    wait_idle();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        set_req(0, a, b);
        wait_grant(0);
      end
    wait_idle();
    pulse_reset();
    rsp_ready = 1'b0;
    set_req(2, 9, 7);
    wait_grant(2);
    set_req(0, 1, 1);
    for (int n = 0; n < 10 && !rsp_valid; n++) tick();
    repeat (10) begin
      check("bp_prod", int'(rsp_prod), 8'h3F);
      check("bp_id", int'(rsp_id), 2);
      check("bp_ready", int'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
`ifdef MUL_SHARE_ARBITER_STATS_EN
    check("bp_stall_total", int'(stall_cycles), 10);
    check("bp_op_total", int'(op_count), 1);
`endif
    wait_grant(0);
    wait_idle();
    set_req(3, 15, 15);
    wait_grant(3);
    wait_idle();
    set_req(0, 4, 11);
    set_req(3, 13, 2);
    wait_any(g);
    check("wrap_grant", int'(g), 1);
    req_valid[0] = 1'b0;
    wait_grant(3);
    wait_idle();
    repeat (1500) begin
      tick();
      rsp_ready = ($urandom_range(9) < 7);
      req_valid &= ~last_rdy;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(3) == 0) set_req(i, $urandom_range(15), $urandom_range(15));
        else if (req_valid[i] && $urandom_range(30) == 0) req_valid[i] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
